// File: rtl/inst_fetch_bridge.sv
// One-entry instruction fetch buffer between the core's ROM port and a slow handshaked memory.
// Misses stall the core; a timed-out read is returned to the core as a NOP.
module inst_fetch_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               buf_valid_r;
  logic [ADDR_W-1:0]  buf_addr_r;
  logic [DATA_W-1:0]  buf_data_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               discard_r;
  logic               err_r;

  logic [ADDR_W-1:0]  waddr_s;
  logic               hit_s;
  logic               miss_s;
  logic               issue_s;
  logic               done_s;
  logic               tmo_s;

  // Byte address to word address; the low two bits never take part in a compare.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  assign waddr_s    = word_addr(addr_i);
  assign hit_s      = ce_i & buf_valid_r & (buf_addr_r == waddr_s) & ~flush_i;
  assign miss_s     = ce_i & ~hit_s;
  assign mem_req_o  = (state_r == ST_REQ);
  assign mem_addr_o = mem_addr_r;
  assign err_o      = err_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state and termination decode; ready has priority over the timeout terminal count
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    done_s      = 1'b0;
    tmo_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (miss_s && !flush_i) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          tmo_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs to the core; forced quiet while reset is asserted
  always_comb begin
    data_o  = '0;
    stall_o = 1'b0;
    if (!rst) begin
      data_o  = '0;
      stall_o = 1'b0;
    end else if (hit_s) begin
      data_o  = buf_data_r;
      stall_o = 1'b0;
    end else if (miss_s) begin
      data_o  = '0;
      stall_o = 1'b1;
    end else begin
      data_o  = '0;
      stall_o = 1'b0;
    end
  end

  // Request address, timeout counter, discard flag, fetch buffer and error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_r  <= '0;
      cnt_r       <= '0;
      discard_r   <= 1'b0;
      buf_valid_r <= 1'b0;
      buf_addr_r  <= '0;
      buf_data_r  <= '0;
      err_r       <= 1'b0;
    end else begin
      err_r <= tmo_s;

      if (issue_s) begin
        mem_addr_r <= waddr_s;
        cnt_r      <= '0;
        discard_r  <= 1'b0;
      end else if (state_r == ST_REQ) begin
        cnt_r <= cnt_r + CNT_ONE;
        if (flush_i) begin
          discard_r <= 1'b1;
        end else begin
          discard_r <= discard_r;
        end
      end else begin
        cnt_r     <= cnt_r;
        discard_r <= discard_r;
      end

      // A flush in the completing cycle also discards the returning word.
      if (flush_i) begin
        buf_valid_r <= 1'b0;
      end else if (done_s && !discard_r) begin
        buf_valid_r <= 1'b1;
        buf_addr_r  <= mem_addr_r;
        buf_data_r  <= mem_rdata_i;
      end else if (tmo_s && !discard_r) begin
        buf_valid_r <= 1'b1;
        buf_addr_r  <= mem_addr_r;
        buf_data_r  <= '0;
      end else begin
        buf_valid_r <= buf_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: expected instruction words are queued when the
// memory response is driven and compared when the core stall releases.
module tb_inst_fetch_bridge;

  logic        clk;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] data_o;
  logic        stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic        err_o;

  int          checks;
  int          errors;
  logic [31:0] exp_q[$];

  inst_fetch_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .data_o(data_o),
    .stall_o(stall_o), .flush_i(flush_i), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, data_o);
    end else begin
      e = exp_q.pop_front();
      chk(tag, data_o, e);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    ce_i        = 1'b1;
    addr_i      = 32'h0;
    flush_i     = 1'b0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;

    // Reset held with fetch enabled: everything quiet
    repeat (3) cyc();
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_err", {31'd0, err_o}, 32'd0);

    // Minimum-latency miss on word 0
    cyc();
    rst = 1'b1;
    #1;
    chk("min_c0_stall", {31'd0, stall_o}, 32'd1);
    chk("min_c0_req", {31'd0, mem_req_o}, 32'd0);
    cyc();
    chk("min_c1_req", {31'd0, mem_req_o}, 32'd1);
    chk("min_c1_addr", mem_addr_o, 32'h0);
    chk("min_c1_stall", {31'd0, stall_o}, 32'd1);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h34011100;
    exp_q.push_back(32'h34011100);
    cyc();
    mem_ready_i = 1'b0;
    #1;
    chk("min_c2_stall", {31'd0, stall_o}, 32'd0);
    chk_pop("min_c2_data");
    chk("min_c2_req", {31'd0, mem_req_o}, 32'd0);

    // Same word, different byte offset: hit without a request
    cyc();
    addr_i = 32'h2;
    #1;
    chk("hit_data", data_o, 32'h34011100);
    chk("hit_stall", {31'd0, stall_o}, 32'd0);
    cyc();
    chk("hit_req", {31'd0, mem_req_o}, 32'd0);

    // Fetch disabled on an uncached address: NOP, no stall, no request
    ce_i   = 1'b0;
    addr_i = 32'h20;
    #1;
    chk("dis_data", data_o, 32'h0);
    chk("dis_stall", {31'd0, stall_o}, 32'd0);
    cyc();
    chk("dis_req", {31'd0, mem_req_o}, 32'd0);

    // Slow memory: ready after 5 wait cycles
    ce_i   = 1'b1;
    addr_i = 32'h4;
    #1;
    chk("slow_c0_stall", {31'd0, stall_o}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("slow_req", {31'd0, mem_req_o}, 32'd1);
      chk("slow_addr", mem_addr_o, 32'h4);
      chk("slow_stall", {31'd0, stall_o}, 32'd1);
      chk("slow_err", {31'd0, err_o}, 32'd0);
      if (i == 6) begin
        mem_ready_i = 1'b1;
        mem_rdata_i = 32'h34020020;
        exp_q.push_back(32'h34020020);
      end
    end
    cyc();
    mem_ready_i = 1'b0;
    #1;
    chk_pop("slow_data");
    chk("slow_done_stall", {31'd0, stall_o}, 32'd0);
    chk("slow_done_err", {31'd0, err_o}, 32'd0);

    // Timeout: memory never answers, request lasts exactly TIMEOUT cycles
    cyc();
    addr_i = 32'h8;
    #1;
    chk("tmo_c0_stall", {31'd0, stall_o}, 32'd1);
    exp_q.push_back(32'h0);
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("tmo_req", {31'd0, mem_req_o}, 32'd1);
      chk("tmo_err_early", {31'd0, err_o}, 32'd0);
      chk("tmo_stall", {31'd0, stall_o}, 32'd1);
    end
    cyc();
    chk("tmo_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("tmo_err", {31'd0, err_o}, 32'd1);
    chk("tmo_stall_done", {31'd0, stall_o}, 32'd0);
    chk_pop("tmo_data");
    cyc();
    chk("tmo_err_pulse", {31'd0, err_o}, 32'd0);
    chk("tmo_no_reissue", {31'd0, mem_req_o}, 32'd0);

    // Flush during an in-flight read: result discarded, word re-requested
    addr_i = 32'hC;
    #1;
    chk("fl_c0_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    chk("fl_req", {31'd0, mem_req_o}, 32'd1);
    chk("fl_addr", mem_addr_o, 32'hC);
    flush_i = 1'b1;
    #1;
    chk("fl_flush_stall", {31'd0, stall_o}, 32'd1);
    cyc();
    flush_i     = 1'b0;
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("fl_req_held", {31'd0, mem_req_o}, 32'd1);
    cyc();
    mem_ready_i = 1'b0;
    #1;
    chk("fl_discard_data", data_o, 32'h0);
    chk("fl_discard_stall", {31'd0, stall_o}, 32'd1);
    chk("fl_idle_gap", {31'd0, mem_req_o}, 32'd0);
    cyc();
    chk("fl_rereq", {31'd0, mem_req_o}, 32'd1);
    chk("fl_rereq_addr", mem_addr_o, 32'hC);
    mem_ready_i = 1'b1;
    mem_rdata_i = 32'h11223344;
    exp_q.push_back(32'h11223344);
    cyc();
    mem_ready_i = 1'b0;
    #1;
    chk_pop("fl_refill_data");
    chk("fl_refill_stall", {31'd0, stall_o}, 32'd0);

    // Asynchronous reset mid-request
    cyc();
    addr_i = 32'h10;
    cyc();
    chk("ar_req_before", {31'd0, mem_req_o}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_req", {31'd0, mem_req_o}, 32'd0);
    chk("ar_stall", {31'd0, stall_o}, 32'd0);
    chk("ar_err", {31'd0, err_o}, 32'd0);
    chk("ar_data", data_o, 32'h0);
    cyc();
    rst    = 1'b1;
    addr_i = 32'hC;
    #1;
    chk("ar_first_miss", {31'd0, stall_o}, 32'd1);
    chk("ar_first_data", data_o, 32'h0);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
